csa_mult_pipe: RTL and testbench

- Parametrised successor to the team's fixed-size carry-save multiplier.
- Computes an AW x BW product, selectable per operation as unsigned or two's-complement (Baugh-Wooley).
- Reduces partial products through a pipelined CSA tree of STAGES register stages, with valid/ready flow control.
- Drives the carry-save pair for downstream fused adders, plus a resolved product for consumers that need a binary result.

---
 rtl/csa_mult_pipe.sv | 215 +++++++++++++++++++++
 tb/tb_csa_mult_pipe.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_mult_pipe.sv
// Pipelined carry-save multiplier, AW x BW, unsigned or Baugh-Wooley signed.
// Partial products are reduced by a 3:2 (full-adder) tree that is split across
// the register stages; the output carries both the carry-save pair and the
// resolved binary product.
module csa_mult_pipe #(
    parameter int AW     = 5,
    parameter int BW     = 3,
    parameter int STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [AW-1:0]      a,
    input  logic [BW-1:0]      b,
    input  logic               tc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [AW+BW-1:0]   cs_sum,
    output logic [AW+BW-1:0]   cs_carry,
    output logic [AW+BW-1:0]   product
);

    localparam int PW   = AW + BW;
    // BW partial-product rows plus one row for the signed-mode constant
    localparam int R0   = BW + 1;
    localparam int SPAN = (STAGES > 1) ? STAGES - 1 : 1;

    typedef logic [PW-1:0] rows_t [R0];

    localparam logic [PW-1:0] ONE      = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] TC_CONST = (ONE << (AW - 1)) + (ONE << (BW - 1)) + (ONE << (PW - 1));

    // Number of live rows after lvl levels of 3:2 reduction.
    function automatic int rows_at(input int lvl);
        int n;
        n = R0;
        for (int k = 0; k < lvl; k++) n = 2 * (n / 3) + (n % 3);
        return n;
    endfunction

    // Levels needed to bring R0 rows down to a carry-save pair.
    function automatic int tree_depth();
        int n;
        int d;
        n = R0;
        d = 0;
        for (int k = 0; k < 64; k++) begin
            if (n > 2) begin
                n = 2 * (n / 3) + (n % 3);
                d = d + 1;
            end
        end
        return d;
    endfunction

    localparam int DEPTH = tree_depth();

    // Tree depth reached at the output of register stage k. Levels are spread
    // evenly; when there are more stages than levels the tail stages only delay.
    function automatic int cut(input int k);
        int c;
        if (k == 0) begin
            c = 0;
        end else if (SPAN <= DEPTH) begin
            c = (k * DEPTH + SPAN - 1) / SPAN;
        end else begin
            c = (k < DEPTH) ? k : DEPTH;
        end
        return c;
    endfunction

    // Partial-product rows, weight-aligned, with Baugh-Wooley inversions and
    // correction constant applied in signed mode.
    function automatic rows_t build_pp(input logic [AW-1:0] av, input logic [BW-1:0] bv,
                                       input logic tcv);
        rows_t           r;
        logic [AW-1:0]   inv;
        logic [AW-1:0]   pp;
        logic [PW-1:0]   ext;
        r = '{default: '0};
        for (int j = 0; j < BW; j++) begin
            inv  = (j < BW - 1) ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
            pp   = (av & {AW{bv[j]}}) ^ ({AW{tcv}} & inv);
            ext  = {{BW{1'b0}}, pp};
            r[j] = ext << j;
        end
        r[BW] = tcv ? TC_CONST : '0;
        return r;
    endfunction

    // Apply tree levels [lv_from, lv_to): each group of three rows becomes a
    // sum row and a left-shifted majority (carry) row; leftover rows pass through.
    function automatic rows_t reduce(input rows_t rin, input int lv_from, input int lv_to);
        rows_t         cur;
        rows_t         nxt;
        logic [PW-1:0] x;
        logic [PW-1:0] y;
        logic [PW-1:0] z;
        logic [PW-1:0] maj;
        int            n;
        int            g;
        int            rem;
        cur = rin;
        n   = rows_at(lv_from);
        for (int l = 0; l < DEPTH; l++) begin
            if (l >= lv_from && l < lv_to) begin
                g   = n / 3;
                rem = n - 3 * g;
                nxt = '{default: '0};
                for (int i = 0; i < R0 / 3; i++) begin
                    if (i < g) begin
                        x            = cur[3*i];
                        y            = cur[3*i+1];
                        z            = cur[3*i+2];
                        maj          = (x & y) | (x & z) | (y & z);
                        nxt[2*i]     = x ^ y ^ z;
                        nxt[2*i+1]   = {maj[PW-2:0], 1'b0};
                    end
                end
                for (int j = 0; j < 2; j++) begin
                    if (j < rem) nxt[2*g+j] = cur[3*g+j];
                end
                cur = nxt;
                n   = 2 * g + rem;
            end
        end
        return cur;
    endfunction

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] ld;
    logic              rst_done;
    logic              accept;
    logic [AW-1:0]     a_r;
    logic [BW-1:0]     b_r;
    logic              tc_r;
    rows_t             pp0;
    rows_t             last_rows;

    // Stage k may load when any stage from k to the output is empty or the consumer takes the result
    always_comb begin
        logic full;
        ld = '0;
        for (int k = 0; k < STAGES; k++) begin
            full = 1'b1;
            for (int j = 0; j < STAGES; j++) full = full & (v[j] | (j < k));
            ld[k] = out_ready | ~full;
        end
    end

    assign in_ready  = ld[0] & rst_done;
    assign accept    = in_valid & in_ready;
    assign out_valid = v[STAGES-1];

    // Valid bits move with their stage; rst_done opens the input one edge after release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v        <= '0;
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            if (ld[0]) v[0] <= accept;
            for (int k = 1; k < STAGES; k++) begin
                if (ld[k]) v[k] <= v[k-1];
            end
        end
    end

    // Operand register: captures a, b and mode on every accepted transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r  <= '0;
            b_r  <= '0;
            tc_r <= 1'b0;
        end else if (accept) begin
            a_r  <= a;
            b_r  <= b;
            tc_r <= tc;
        end
    end

    assign pp0 = build_pp(a_r, b_r, tc_r);

    if (STAGES > 1) begin : g_pipe
        rows_t st   [STAGES-1];
        rows_t feed [STAGES-1];

        // Input rows of each tree stage: PP rows for the first, previous stage afterwards
        always_comb begin
            feed[0] = pp0;
            for (int k = 1; k < STAGES - 1; k++) feed[k] = st[k-1];
        end

        // Each stage advances the tree from its entry depth to its exit depth
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < STAGES - 1; k++) st[k] <= '{default: '0};
            end else begin
                for (int k = 1; k < STAGES; k++) begin
                    if (ld[k] && v[k-1]) st[k-1] <= reduce(feed[k-1], cut(k-1), cut(k));
                end
            end
        end

        assign last_rows = st[STAGES-2];
    end else begin : g_comb
        assign last_rows = reduce(pp0, 0, DEPTH);
    end

    assign cs_sum   = last_rows[0];
    assign cs_carry = last_rows[1];
    assign product  = cs_sum + cs_carry;

endmodule

// File: tb/tb_csa_mult_pipe.sv
// Directed and scoreboard tests for csa_mult_pipe: four 5x3 instances with
// STAGES=1..4 sharing operands, plus one 8x8 STAGES=3 instance.
module tb_csa_mult_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  iv;
    logic [3:0]  ir;
    logic [3:0]  ov;
    logic [3:0]  orr;
    logic [4:0]  a;
    logic [2:0]  b;
    logic        tc;
    logic [7:0]  cs [4];
    logic [7:0]  cc [4];
    logic [7:0]  pr [4];

    logic        iv8, ir8, ov8, or8, tc8;
    logic [7:0]  a8, b8;
    logic [15:0] s8, c8, p8;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        csa_mult_pipe #(.AW(5), .BW(3), .STAGES(g + 1)) u_dut (
            .clk(clk), .rst(rst), .in_valid(iv[g]), .in_ready(ir[g]),
            .a(a), .b(b), .tc(tc), .out_valid(ov[g]), .out_ready(orr[g]),
            .cs_sum(cs[g]), .cs_carry(cc[g]), .product(pr[g]));
    end

    csa_mult_pipe #(.AW(8), .BW(8), .STAGES(3)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .tc(tc8), .out_valid(ov8), .out_ready(or8),
        .cs_sum(s8), .cs_carry(c8), .product(p8));

    task automatic test_reset;
        rst = 1'b1; iv = 4'h0; orr = 4'hF; a = 5'd0; b = 3'd0; tc = 1'b0;
        iv8 = 1'b0; or8 = 1'b1; a8 = 8'd0; b8 = 8'd0; tc8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++) begin
            tests++;
            if (ov[g] !== 1'b0 || pr[g] !== 8'h00 || cs[g] !== 8'h00 || cc[g] !== 8'h00) begin
                fails++;
                $display("FAIL reset_out[%0d]: valid=%b prod=%h sum=%h carry=%h, want all 0",
                         g, ov[g], pr[g], cs[g], cc[g]);
            end
        end
        tests++;
        if (ov8 !== 1'b0 || p8 !== 16'h0000 || s8 !== 16'h0000 || c8 !== 16'h0000) begin
            fails++;
            $display("FAIL reset_out8: valid=%b prod=%h sum=%h carry=%h, want all 0", ov8, p8, s8, c8);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (ir !== 4'hF || ir8 !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b/%b, want 1111/1", ir, ir8);
        end
    endtask

    task automatic test_signed_basic;
        logic [7:0] sum8;
        iv[1] = 1'b1; a = 5'b10000; b = 3'b011; tc = 1'b1;
        @(posedge clk);
        #1;
        iv[1] = 1'b0;
        tests++;
        if (ov[1] !== 1'b0) begin
            fails++;
            $display("FAIL signed_early: out_valid=%b one edge too soon, want 0", ov[1]);
        end
        @(posedge clk);
        #1;
        sum8 = cs[1] + cc[1];
        tests++;
        if (ov[1] !== 1'b1 || pr[1] !== 8'hD0) begin
            fails++;
            $display("FAIL signed_m16x3: valid=%b prod=%h, want 1 d0", ov[1], pr[1]);
        end
        tests++;
        if (sum8 !== 8'hD0) begin
            fails++;
            $display("FAIL signed_cs_pair: sum+carry=%h, want d0", sum8);
        end
        @(posedge clk);
        #1;
        tests++;
        if (ov[1] !== 1'b0) begin
            fails++;
            $display("FAIL signed_dup: out_valid=%b after consume, want 0", ov[1]);
        end
    endtask

    task automatic test_back_to_back;
        iv[1] = 1'b1; a = 5'b10000; b = 3'b100; tc = 1'b1;
        @(posedge clk);
        #1;
        a = 5'd31; b = 3'd7; tc = 1'b0;
        @(posedge clk);
        #1;
        iv[1] = 1'b0;
        tests++;
        if (ov[1] !== 1'b1 || pr[1] !== 8'h40) begin
            fails++;
            $display("FAIL b2b_first: valid=%b prod=%h, want 1 40", ov[1], pr[1]);
        end
        @(posedge clk);
        #1;
        tests++;
        if (ov[1] !== 1'b1 || pr[1] !== 8'hD9) begin
            fails++;
            $display("FAIL b2b_second: valid=%b prod=%h, want 1 d9", ov[1], pr[1]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure;
        int         nxt;
        int         got;
        logic       acc;
        logic [7:0] snap_s, snap_c;
        orr[1] = 1'b0; nxt = 1; got = 0; tc = 1'b0; b = 3'd1; a = 5'd1; iv[1] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            acc = iv[1] & ir[1];
            @(posedge clk);
            #1;
            if (acc) nxt++;
            a = 5'(nxt);
            iv[1] = (nxt <= 4);
        end
        tests++;
        if (nxt !== 3 || ir[1] !== 1'b0) begin
            fails++;
            $display("FAIL bp_fill: accepted=%0d in_ready=%b, want 2 0", nxt - 1, ir[1]);
        end
        tests++;
        if (ov[1] !== 1'b1 || pr[1] !== 8'd1) begin
            fails++;
            $display("FAIL bp_head: valid=%b prod=%h, want 1 01", ov[1], pr[1]);
        end
        snap_s = cs[1]; snap_c = cc[1];
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (pr[1] !== 8'd1 || cs[1] !== snap_s || cc[1] !== snap_c || ir[1] !== 1'b0) begin
            fails++;
            $display("FAIL bp_hold: prod=%h sum=%h carry=%h ready=%b, want 01 %h %h 0",
                     pr[1], cs[1], cc[1], ir[1], snap_s, snap_c);
        end
        orr[1] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            acc = iv[1] & ir[1];
            if (ov[1] === 1'b1) begin
                tests++;
                if (pr[1] !== 8'(got + 1)) begin
                    fails++;
                    $display("FAIL bp_order: prod=%h, want %h", pr[1], 8'(got + 1));
                end
                got++;
            end
            @(posedge clk);
            #1;
            if (acc) nxt++;
            a = 5'(nxt);
            iv[1] = (nxt <= 4);
        end
        tests++;
        if (got !== 4) begin
            fails++;
            $display("FAIL bp_count: results=%0d, want 4", got);
        end
    endtask

    task automatic test_reset_midflight;
        logic seen;
        orr[1] = 1'b0; tc = 1'b0; b = 3'd1; a = 5'd5; iv[1] = 1'b1;
        @(posedge clk);
        #1;
        a = 5'd6;
        @(posedge clk);
        #1;
        iv[1] = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (ov[1] !== 1'b0 || pr[1] !== 8'h00 || cs[1] !== 8'h00 || cc[1] !== 8'h00) begin
            fails++;
            $display("FAIL midrst_async: valid=%b prod=%h sum=%h carry=%h, want all 0",
                     ov[1], pr[1], cs[1], cc[1]);
        end
        @(negedge clk);
        rst = 1'b0;
        orr[1] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (ov[1] === 1'b1) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL midrst_stale: out_valid seen=%b, want 0", seen);
        end
        @(posedge clk);
        #1;
        a = 5'd3; b = 3'd2; iv[1] = 1'b1;
        @(posedge clk);
        #1;
        iv[1] = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (ov[1] !== 1'b1 || pr[1] !== 8'd6) begin
            fails++;
            $display("FAIL midrst_next: valid=%b prod=%h, want 1 06", ov[1], pr[1]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency;
        int   lat;
        logic acc;
        for (int s = 0; s < 4; s++) begin
            orr[s] = 1'b1; a = 5'd7; b = 3'd5; tc = 1'b0; iv[s] = 1'b1;
            @(negedge clk);
            acc = ir[s];
            @(posedge clk);
            #1;
            iv[s] = 1'b0;
            lat = 0;
            while (ov[s] !== 1'b1 && lat < 10) begin
                @(posedge clk);
                #1;
                lat++;
            end
            tests++;
            if (acc !== 1'b1 || lat !== s || pr[s] !== 8'd35) begin
                fails++;
                $display("FAIL latency[S=%0d]: ready=%b edges=%0d prod=%h, want 1 %0d 23",
                         s + 1, acc, lat, pr[s], s);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_exhaustive;
        logic [7:0] q [$];
        logic [7:0] want;
        logic [7:0] sum8;
        logic       acc;
        int         idx;
        int         sa, sb;
        for (int s = 0; s < 4; s++) begin
            idx = 0;
            q.delete();
            for (int cyc = 0; cyc < 3000 && (idx < 512 || q.size() > 0); cyc++) begin
                a = 5'(idx); b = 3'(idx >> 5); tc = (idx >= 256);
                iv[s] = (idx < 512) && ($urandom_range(0, 3) != 0);
                orr[s] = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (ov[s] === 1'b1 && orr[s] === 1'b1) begin
                    want = (q.size() > 0) ? q.pop_front() : 8'hxx;
                    sum8 = cs[s] + cc[s];
                    tests++;
                    if (pr[s] !== want) begin
                        fails++;
                        $display("FAIL exh_prod[S=%0d]: prod=%h, want %h", s + 1, pr[s], want);
                    end
                    tests++;
                    if (sum8 !== want) begin
                        fails++;
                        $display("FAIL exh_cs[S=%0d]: sum+carry=%h, want %h", s + 1, sum8, want);
                    end
                end
                acc = iv[s] & ir[s];
                if (acc) begin
                    sa = tc ? int'($signed(a)) : int'({1'b0, a});
                    sb = tc ? int'($signed(b)) : int'({1'b0, b});
                    q.push_back(8'(sa * sb));
                end
                @(posedge clk);
                #1;
                if (acc) idx++;
            end
            iv[s] = 1'b0;
            orr[s] = 1'b1;
            tests++;
            if (idx !== 512 || q.size() !== 0) begin
                fails++;
                $display("FAIL exh_done[S=%0d]: issued=%0d pending=%0d, want 512 0", s + 1, idx, q.size());
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_8x8;
        logic [15:0] q [$];
        logic [15:0] want;
        logic        acc;
        int          done;
        int          sa, sb;
        or8 = 1'b1; tc8 = 1'b1; a8 = 8'h80; b8 = 8'h80; iv8 = 1'b1;
        @(posedge clk);
        #1;
        a8 = 8'h7F;
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (ov8 !== 1'b1 || p8 !== 16'h4000) begin
            fails++;
            $display("FAIL m8_80x80: valid=%b prod=%h, want 1 4000", ov8, p8);
        end
        @(posedge clk);
        #1;
        tests++;
        if (ov8 !== 1'b1 || p8 !== 16'hC080) begin
            fails++;
            $display("FAIL m8_7fx80: valid=%b prod=%h, want 1 c080", ov8, p8);
        end
        @(posedge clk);
        #1;
        done = 0;
        a8 = 8'($urandom); b8 = 8'($urandom); tc8 = 1'($urandom);
        for (int cyc = 0; cyc < 40000 && (done < 10000 || q.size() > 0); cyc++) begin
            iv8 = (done < 10000) && ($urandom_range(0, 3) != 0);
            or8 = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (ov8 === 1'b1 && or8 === 1'b1) begin
                want = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
                tests++;
                if (p8 !== want || 16'(s8 + c8) !== want) begin
                    fails++;
                    $display("FAIL m8_rand: prod=%h sum+carry=%h, want %h", p8, 16'(s8 + c8), want);
                end
            end
            acc = iv8 & ir8;
            if (acc) begin
                sa = tc8 ? int'($signed(a8)) : int'({1'b0, a8});
                sb = tc8 ? int'($signed(b8)) : int'({1'b0, b8});
                q.push_back(16'(sa * sb));
            end
            @(posedge clk);
            #1;
            if (acc) begin
                done++;
                a8 = 8'($urandom); b8 = 8'($urandom); tc8 = 1'($urandom);
            end
        end
        iv8 = 1'b0;
        tests++;
        if (done !== 10000 || q.size() !== 0) begin
            fails++;
            $display("FAIL m8_done: issued=%0d pending=%0d, want 10000 0", done, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_signed_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_latency();
        test_exhaustive();
        test_8x8();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
